bht_2bit_predictor: RTL and testbench
=====================================

// Module: bht_2bit_predictor
// PURPOSE
//  Branch history table for the cv32a6 frontend: 2-bit saturating counters indexed by fetch PC.
//  Sits beside the BTB/RAS in the frontend, consumes the BHT sizing from the core config package,
//  and predicts per instruction slot of the current fetch. Updated by the resolved-branch port
//  coming back from the execute stage.
// PARAMETERS
//  VLEN            32   virtual address width
//  NR_ENTRIES      128  total counters (= config BHT entries); power of two, >= INSTR_PER_FETCH
//  INSTR_PER_FETCH 2    slots per fetch (32-bit fetch, C ext => 2 halfword slots)
//  derived: ROWS=NR_ENTRIES/INSTR_PER_FETCH (64); ROW_BITS=$clog2(ROWS) (6); SLOT_BITS=$clog2(INSTR_PER_FETCH) (1); OFFSET=1
// PORTS
//  clk_i               in   1                    clock
//  rst_ni              in   1                    synchronous reset, active low
//  flush_i             in   1                    invalidate all entries
//  debug_mode_i        in   1                    core in debug mode: suppress updates
//  vpc_i               in   VLEN                 fetch PC to predict for
//  bht_update_valid_i  in   1                    resolved conditional branch update
//  bht_update_pc_i     in   VLEN                 PC of resolved branch
//  bht_update_taken_i  in   1                    resolved direction
//  bht_valid_o         out  INSTR_PER_FETCH      per-slot prediction valid
//  bht_taken_o         out  INSTR_PER_FETCH      per-slot predicted taken
// BEHAVIOUR
//  - Storage: ROWS x INSTR_PER_FETCH entries of {valid, cnt[1:0]}; flops, no SRAM.
//  - Index: row = pc[ROW_BITS+SLOT_BITS+OFFSET-1 : SLOT_BITS+OFFSET] (pc[7:2]); slot = pc[SLOT_BITS+OFFSET-1:OFFSET] (pc[1]).
//  - Read: combinational, zero latency, row from vpc_i; slot i -> bht_valid_o[i]=valid, bht_taken_o[i]=cnt[1].
//    Outputs derive from state only, so after reset both are all-zero.
//  - Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
//  - Update (registered, visible next cycle), when bht_update_valid_i && !debug_mode_i:
//    entry invalid -> valid<=1, cnt<= taken ? 10 : 01;
//    entry valid   -> taken: cnt<=cnt+1 saturating at 11; not taken: cnt<=cnt-1 saturating at 00.
//  - No read bypass: an update and a read of the same entry in one cycle -> read returns pre-update value.
//  - flush_i: all valid<=0 next edge; counters untouched. flush_i && update same cycle -> flush wins,
//    update dropped (entry ends invalid).
//  - Reset (!rst_ni at posedge): all valid<=0, all cnt<=00; dominates flush and update. Reset mid-stream
//    discards any update presented that cycle.
//  - Upper PC bits above the index are ignored (aliasing intended); wrap-around of row index is natural modulo ROWS.
// STRUCTURE
//  - ariane_pkg: bht_update_t {valid, pc, taken}, bht_prediction_t {valid, taken}; counter encoding localparams.
//  - One sub-module: sat_counter2 (2-bit saturating inc/dec, combinational next-state); instantiated
//    once on the update path, not per entry.
//  - Top: entry array, index decode, update write-enable, flush/reset priority.
// TESTING
//  1 reset: hold rst_ni=0 2 cycles, release; any vpc_i -> bht_valid_o=00, bht_taken_o=00.
//  2 first update: update pc=0x0000_0104 taken=1; next cycle vpc_i=0x0000_0104 -> valid=01? no: slot0 valid=1,
//    taken=1 (cnt=10); vpc_i=0x0000_0106 slot1 valid=0.
//  3 saturation: 4 taken updates pc=0x100 -> cnt=11; then 1 NT -> cnt=10, taken still 1; 2 more NT -> cnt=00, taken=0;
//    further NT keeps 00.
//  4 aliasing/index: update pc=0x0000_0100 taken, read vpc_i=0x0000_0200 (row 0, same slot) -> valid=1 taken=1;
//    vpc_i=0x0000_0104 (row 1) -> valid=0.
//  5 flush priority: flush_i=1 with update pc=0x108 same cycle -> next cycle all valid=0; subsequent update on
//    previously trained entry re-inits to 10/01, not saturating from old cnt.
//  6 debug/collision: debug_mode_i=1 update -> no change; same-cycle read+update of one entry -> old value that
//    cycle, new value next cycle.

Source files
------------

// File: rtl/bht_2bit_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bht_2bit_predictor_pkg
// Description : Shared types and counter encodings for the 2-bit BHT.
// Revision    : 1.0 - initial release
// ============================================================================
package bht_2bit_predictor_pkg;

    localparam int VLEN = 32;

    localparam logic [1:0] c_CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] c_CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] c_CNT_WEAK_T    = 2'b10;
    localparam logic [1:0] c_CNT_STRONG_T  = 2'b11;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

endpackage

`default_nettype wire

// File: rtl/bht_2bit_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Combinational next-state for a 2-bit saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import bht_2bit_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != c_CNT_STRONG_T) begin
                cnt_o = cnt_i + 2'd1;
            end
        end else begin
            if (cnt_i != c_CNT_STRONG_NT) begin
                cnt_o = cnt_i - 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bht_2bit_predictor.sv
`default_nettype none
// ============================================================================
// Module      : bht_2bit_predictor
// Description : Flop-based branch history table of 2-bit counters, per-slot read.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_2bit_predictor
    import bht_2bit_predictor_pkg::*;
#(
    parameter int NR_ENTRIES      = 128,
    parameter int INSTR_PER_FETCH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       bht_update_valid_i,
    input  logic [VLEN-1:0]            bht_update_pc_i,
    input  logic                       bht_update_taken_i,
    output logic [INSTR_PER_FETCH-1:0] bht_valid_o,
    output logic [INSTR_PER_FETCH-1:0] bht_taken_o
);

    localparam int ROWS      = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int ROW_BITS  = $clog2(ROWS);
    localparam int SLOT_BITS = $clog2(INSTR_PER_FETCH);
    localparam int OFFSET    = 1;

    logic [ROWS-1:0][INSTR_PER_FETCH-1:0]      valid_q;
    logic [ROWS-1:0][INSTR_PER_FETCH-1:0][1:0] cnt_q;

    bht_update_t                            w_upd;
    bht_prediction_t [INSTR_PER_FETCH-1:0]  w_pred;
    logic [ROW_BITS-1:0]                    w_rd_row;
    logic [ROW_BITS-1:0]                    w_wr_row;
    logic [SLOT_BITS-1:0]                   w_wr_slot;
    logic                                   w_wr_en;
    logic                                   w_wr_valid;
    logic [1:0]                             w_wr_cnt;
    logic [1:0]                             w_sat_cnt;
    logic [1:0]                             cnt_d;

    assign w_upd = '{valid: bht_update_valid_i, pc: bht_update_pc_i, taken: bht_update_taken_i};

    // Bits above the index are deliberately dropped: distant PCs alias onto the same row.
    assign w_rd_row  = vpc_i[ROW_BITS+SLOT_BITS+OFFSET-1 : SLOT_BITS+OFFSET];
    assign w_wr_row  = w_upd.pc[ROW_BITS+SLOT_BITS+OFFSET-1 : SLOT_BITS+OFFSET];
    assign w_wr_slot = w_upd.pc[SLOT_BITS+OFFSET-1 : OFFSET];

    assign w_wr_en    = w_upd.valid && !debug_mode_i;
    assign w_wr_valid = valid_q[w_wr_row][w_wr_slot];
    assign w_wr_cnt   = cnt_q[w_wr_row][w_wr_slot];

    sat_counter2 u_sat_counter2 (
        .cnt_i   (w_wr_cnt),
        .taken_i (w_upd.taken),
        .cnt_o   (w_sat_cnt)
    );

    // A freshly allocated entry starts in the weak state of the observed direction.
    always_comb begin
        cnt_d = w_sat_cnt;
        if (!w_wr_valid) begin
            cnt_d = w_upd.taken ? c_CNT_WEAK_T : c_CNT_WEAK_NT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (w_wr_en) begin
            valid_q[w_wr_row][w_wr_slot] <= 1'b1;
            cnt_q[w_wr_row][w_wr_slot]   <= cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_slot
            assign w_pred[gi].valid = valid_q[w_rd_row][gi];
            assign w_pred[gi].taken = cnt_q[w_rd_row][gi][1];
            assign bht_valid_o[gi]  = w_pred[gi].valid;
            assign bht_taken_o[gi]  = w_pred[gi].taken;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bht_2bit_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bht_2bit_predictor
// Description : Directed self-checking bench for bht_2bit_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bht_2bit_predictor;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        debug_mode_i;
    logic [31:0] vpc_i;
    logic        bht_update_valid_i;
    logic [31:0] bht_update_pc_i;
    logic        bht_update_taken_i;
    logic [1:0]  bht_valid_o;
    logic [1:0]  bht_taken_o;

    int vectors;
    int miscompares;

    bht_2bit_predictor dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .debug_mode_i       (debug_mode_i),
        .vpc_i              (vpc_i),
        .bht_update_valid_i (bht_update_valid_i),
        .bht_update_pc_i    (bht_update_pc_i),
        .bht_update_taken_i (bht_update_taken_i),
        .bht_valid_o        (bht_valid_o),
        .bht_taken_o        (bht_taken_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken);
        bht_update_valid_i = 1'b1;
        bht_update_pc_i    = pc;
        bht_update_taken_i = taken;
        tick();
        bht_update_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni             = 1'b0;
        bht_update_valid_i = 1'b1;
        bht_update_pc_i    = 32'h0000_0104;
        bht_update_taken_i = 1'b1;
        tick();
        tick();
        rst_ni             = 1'b1;
        bht_update_valid_i = 1'b0;
        vpc_i = 32'h0000_0104;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b00 || bht_taken_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_0x104: valid=%b taken=%b required valid=00 taken=00", bht_valid_o, bht_taken_o);
        end
        vpc_i = 32'h0000_0000;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b00 || bht_taken_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_0x000: valid=%b taken=%b required valid=00 taken=00", bht_valid_o, bht_taken_o);
        end
    endtask

    task automatic test_first_update();
        do_update(32'h0000_0104, 1'b1);
        vpc_i = 32'h0000_0104;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b01) begin
            miscompares++;
            $display("FAIL first_update_slot0: valid=%b taken=%b required valid=01 taken=01", bht_valid_o, bht_taken_o);
        end
        vpc_i = 32'h0000_0106;
        #1;
        vectors++;
        if (bht_valid_o[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL first_update_slot1: valid[1]=%b required 0", bht_valid_o[1]);
        end
    endtask

    task automatic test_saturation();
        vpc_i = 32'h0000_0100;
        for (int i = 0; i < 4; i++) do_update(32'h0000_0100, 1'b1);
        #1;
        vectors++;
        if (bht_valid_o[0] !== 1'b1 || bht_taken_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_4taken: valid=%b taken=%b required 1/1", bht_valid_o[0], bht_taken_o[0]);
        end
        do_update(32'h0000_0100, 1'b0);
        vectors++;
        if (bht_taken_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_1nt_from_strong: taken=%b required 1", bht_taken_o[0]);
        end
        do_update(32'h0000_0100, 1'b0);
        vectors++;
        if (bht_taken_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_2nt: taken=%b required 0", bht_taken_o[0]);
        end
        do_update(32'h0000_0100, 1'b0);
        do_update(32'h0000_0100, 1'b0);
        // From 00 one taken step lands on 01, still not-taken; from 01 it would flip.
        do_update(32'h0000_0100, 1'b1);
        vectors++;
        if (bht_valid_o[0] !== 1'b1 || bht_taken_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_floor: valid=%b taken=%b required 1/0", bht_valid_o[0], bht_taken_o[0]);
        end
    endtask

    task automatic test_aliasing();
        do_flush();
        vpc_i = 32'h0000_0100;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b00) begin
            miscompares++;
            $display("FAIL alias_after_flush: valid=%b required 00", bht_valid_o);
        end
        do_update(32'h0000_0100, 1'b1);
        vpc_i = 32'h0000_0200;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b01) begin
            miscompares++;
            $display("FAIL alias_0x200: valid=%b taken=%b required 01/01", bht_valid_o, bht_taken_o);
        end
        vpc_i = 32'h0000_0104;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b00) begin
            miscompares++;
            $display("FAIL alias_row1: valid=%b required 00", bht_valid_o);
        end
        do_update(32'h0000_00FE, 1'b1);
        vpc_i = 32'h0000_01FC;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b10 || bht_taken_o !== 2'b10) begin
            miscompares++;
            $display("FAIL alias_row63: valid=%b taken=%b required 10/10", bht_valid_o, bht_taken_o);
        end
    endtask

    task automatic test_flush_priority();
        do_update(32'h0000_0100, 1'b1);
        flush_i            = 1'b1;
        bht_update_valid_i = 1'b1;
        bht_update_pc_i    = 32'h0000_0108;
        bht_update_taken_i = 1'b1;
        tick();
        flush_i            = 1'b0;
        bht_update_valid_i = 1'b0;
        vpc_i = 32'h0000_0108;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_drops_update: valid=%b required 00", bht_valid_o);
        end
        vpc_i = 32'h0000_0100;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_clears_trained: valid=%b required 00", bht_valid_o);
        end
        do_update(32'h0000_0100, 1'b0);
        vectors++;
        if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_reinit: valid=%b taken=%b required 01/00", bht_valid_o, bht_taken_o);
        end
    endtask

    task automatic test_debug_collision();
        vpc_i        = 32'h0000_010C;
        debug_mode_i = 1'b1;
        do_update(32'h0000_010C, 1'b1);
        debug_mode_i = 1'b0;
        vectors++;
        if (bht_valid_o !== 2'b00) begin
            miscompares++;
            $display("FAIL debug_suppress: valid=%b required 00", bht_valid_o);
        end
        bht_update_valid_i = 1'b1;
        bht_update_pc_i    = 32'h0000_010C;
        bht_update_taken_i = 1'b1;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b00) begin
            miscompares++;
            $display("FAIL collision_same_cycle: valid=%b required 00", bht_valid_o);
        end
        tick();
        bht_update_valid_i = 1'b0;
        vectors++;
        if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b01) begin
            miscompares++;
            $display("FAIL collision_next_cycle: valid=%b taken=%b required 01/01", bht_valid_o, bht_taken_o);
        end
    endtask

    task automatic test_back_to_back();
        do_update(32'h0000_0110, 1'b1);
        do_update(32'h0000_0112, 1'b0);
        vpc_i = 32'h0000_0110;
        #1;
        vectors++;
        if (bht_valid_o !== 2'b11 || bht_taken_o !== 2'b01) begin
            miscompares++;
            $display("FAIL back_to_back: valid=%b taken=%b required 11/01", bht_valid_o, bht_taken_o);
        end
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst_ni             = 1'b0;
        flush_i            = 1'b0;
        debug_mode_i       = 1'b0;
        vpc_i              = '0;
        bht_update_valid_i = 1'b0;
        bht_update_pc_i    = '0;
        bht_update_taken_i = 1'b0;
        #2;
        test_reset();
        test_first_update();
        test_saturation();
        test_aliasing();
        test_flush_priority();
        test_debug_collision();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
